axi_lite_reg_slave: RTL and testbench

- AXI4-Lite responder (subordinate) exposing a word-addressed register file of NUM_REGS 32-bit registers.
- Sits on the slave end of an AXI4-Lite link opposite axi_lite_master and is the target that master sequences run against.
- Independent write and read channels, one outstanding transaction per direction, byte strobes, and SLVERR for out-of-range addresses.

---
 rtl/axi_lite_reg_slave_if.sv | 47 ++++
 rtl/axi_lite_reg_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_slave_if
// Brief    : AXI4-Lite bus bundle with master and slave views.
// Revision : 1.0
// ============================================================================
interface axi_lite_reg_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_slave
// Brief    : AXI4-Lite subordinate with a word-addressed 32-bit register file.
// Revision : 1.0
// ============================================================================
module axi_lite_reg_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input wire                  aclk,
   input wire                  areset_n,
   axi_lite_reg_slave_if.slave s_axi
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int AIDX_W = ADDR_WIDTH - 2;
   localparam logic [AIDX_W:0] C_NUM_REGS = (AIDX_W + 1)'(NUM_REGS);
   localparam logic [1:0] C_OKAY   = 2'b00;
   localparam logic [1:0] C_SLVERR = 2'b10;
   localparam logic [0:0] C_W_IDLE = 1'b0;
   localparam logic [0:0] C_W_RESP = 1'b1;
   localparam logic [0:0] C_R_IDLE = 1'b0;
   localparam logic [0:0] C_R_DATA = 1'b1;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   logic [0:0]            wr_state_q, wr_state_d;
   logic                  aw_lat_q, aw_lat_d;
   logic                  wd_lat_q, wd_lat_d;
   logic [AIDX_W-1:0]     aw_idx_q, aw_idx_d;
   logic [DATA_WIDTH-1:0] wd_data_q, wd_data_d;
   logic [STRB_W-1:0]     wd_strb_q, wd_strb_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;

   logic [0:0]            rd_state_q, rd_state_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   logic                  w_aw_hs, w_wd_hs, w_wr_commit, w_wr_ok;
   logic [AIDX_W-1:0]     w_wr_idx;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic [STRB_W-1:0]     w_wr_strb;
   logic                  w_ar_hs, w_rd_ok;
   logic [AIDX_W-1:0]     w_rd_idx;

   wire w_unused = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   // Readies are only ever high in the idle states, so they double as state qualifiers.
   assign w_aw_hs     = s_axi.awvalid & awready_q;
   assign w_wd_hs     = s_axi.wvalid & wready_q;
   assign w_wr_idx    = aw_lat_q ? aw_idx_q  : s_axi.awaddr[ADDR_WIDTH-1:2];
   assign w_wr_data   = wd_lat_q ? wd_data_q : s_axi.wdata;
   assign w_wr_strb   = wd_lat_q ? wd_strb_q : s_axi.wstrb;
   assign w_wr_commit = (wr_state_q == C_W_IDLE) & (aw_lat_q | w_aw_hs) & (wd_lat_q | w_wd_hs);
   assign w_wr_ok     = {1'b0, w_wr_idx} < C_NUM_REGS;

   assign w_ar_hs  = s_axi.arvalid & arready_q;
   assign w_rd_idx = s_axi.araddr[ADDR_WIDTH-1:2];
   assign w_rd_ok  = {1'b0, w_rd_idx} < C_NUM_REGS;

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;

   always_ff @(posedge aclk or negedge areset_n) begin : p_regfile
      if (!areset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (w_wr_commit && w_wr_ok) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_wr_strb[b]) regs_q[w_wr_idx[IDX_W-1:0]][8*b +: 8] <= w_wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin : p_wr_state
      if (!areset_n) begin
         wr_state_q <= C_W_IDLE;
         aw_lat_q   <= 1'b0;
         wd_lat_q   <= 1'b0;
         aw_idx_q   <= '0;
         wd_data_q  <= '0;
         wd_strb_q  <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= C_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         aw_lat_q   <= aw_lat_d;
         wd_lat_q   <= wd_lat_d;
         aw_idx_q   <= aw_idx_d;
         wd_data_q  <= wd_data_d;
         wd_strb_q  <= wd_strb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
      end
   end

   always_comb begin : p_wr_next
      wr_state_d = wr_state_q;
      case (wr_state_q)
         C_W_IDLE: if (w_wr_commit) wr_state_d = C_W_RESP;
         C_W_RESP: if (s_axi.bready) wr_state_d = C_W_IDLE;
         default:  wr_state_d = C_W_IDLE;
      endcase
   end

   always_comb begin : p_wr_out
      aw_lat_d  = aw_lat_q;
      wd_lat_d  = wd_lat_q;
      aw_idx_d  = aw_idx_q;
      wd_data_d = wd_data_q;
      wd_strb_d = wd_strb_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      case (wr_state_q)
         C_W_IDLE: begin
            if (w_wr_commit) begin
               aw_lat_d  = 1'b0;
               wd_lat_d  = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               bvalid_d  = 1'b1;
               bresp_d   = w_wr_ok ? C_OKAY : C_SLVERR;
            end else begin
               if (w_aw_hs) begin
                  aw_lat_d = 1'b1;
                  aw_idx_d = s_axi.awaddr[ADDR_WIDTH-1:2];
               end
               if (w_wd_hs) begin
                  wd_lat_d  = 1'b1;
                  wd_data_d = s_axi.wdata;
                  wd_strb_d = s_axi.wstrb;
               end
               // Also raises both readies on the first edge out of reset.
               awready_d = ~aw_lat_d;
               wready_d  = ~wd_lat_d;
            end
         end
         C_W_RESP: begin
            if (s_axi.bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
            end
         end
         default: begin
            bvalid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge areset_n) begin : p_rd_state
      if (!areset_n) begin
         rd_state_q <= C_R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= C_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   always_comb begin : p_rd_next
      rd_state_d = rd_state_q;
      case (rd_state_q)
         C_R_IDLE: if (w_ar_hs) rd_state_d = C_R_DATA;
         C_R_DATA: if (s_axi.rready) rd_state_d = C_R_IDLE;
         default:  rd_state_d = C_R_IDLE;
      endcase
   end

   // Reads sample regs_q before any same-edge commit lands, returning the old value.
   always_comb begin : p_rd_out
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (rd_state_q)
         C_R_IDLE: begin
            arready_d = 1'b1;
            if (w_ar_hs) begin
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rdata_d   = w_rd_ok ? regs_q[w_rd_idx[IDX_W-1:0]] : '0;
               rresp_d   = w_rd_ok ? C_OKAY : C_SLVERR;
            end
         end
         C_R_DATA: begin
            if (s_axi.rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
            end
         end
         default: begin
            rvalid_d = 1'b0;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_reg_slave
// Brief    : Directed self-checking bench for axi_lite_reg_slave.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_reg_slave;
   logic clk = 1'b0;
   logic areset_n = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;
   logic [31:0] exp_regs [16];

   axi_lite_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
      .aclk     (clk),
      .areset_n (areset_n),
      .s_axi    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int   n = 0;
      logic aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire;
      bus.awaddr = addr; bus.awvalid = 1'b1;
      bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
      bus.bready = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_fire = bus.awvalid && bus.awready;
         w_fire  = bus.wvalid && bus.wready;
         step(); n++;
         if (aw_fire) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
         if (w_fire)  begin w_done = 1'b1;  bus.wvalid = 1'b0; end
      end
      n = 0;
      while (!bus.bvalid && n < 20) begin step(); n++; end
      tests_run++;
      if (!bus.bvalid) begin
         tests_failed++;
         $display("FAIL write_timeout addr=%h: bvalid=%b, required 1", addr, bus.bvalid);
      end
      resp = bus.bresp;
      step();
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int   n = 0;
      logic done = 1'b0, fire;
      bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
      while (!done && n < 20) begin
         fire = bus.arready;
         step(); n++;
         if (fire) done = 1'b1;
      end
      bus.arvalid = 1'b0;
      n = 0;
      while (!bus.rvalid && n < 20) begin step(); n++; end
      tests_run++;
      if (!bus.rvalid) begin
         tests_failed++;
         $display("FAIL read_timeout addr=%h: rvalid=%b, required 1", addr, bus.rvalid);
      end
      data = bus.rdata;
      resp = bus.rresp;
      step();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b, required 00000",
                  {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
      end
      tests_run++;
      if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h, required 0", {bus.bresp, bus.rresp, bus.rdata});
      end
      areset_n = 1'b1;
      #1;
      tests_run++;
      if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
         tests_failed++;
         $display("FAIL ready_before_edge: got %b, required 000", {bus.awready, bus.wready, bus.arready});
      end
      step();
      tests_run++;
      if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
         tests_failed++;
         $display("FAIL ready_after_edge: got %b, required 111", {bus.awready, bus.wready, bus.arready});
      end
   endtask

   task automatic test_same_cycle_write();
      logic [31:0] d; logic [1:0] r;
      bus.awaddr = 32'h04; bus.awvalid = 1'b1;
      bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      tests_run++;
      if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin
         tests_failed++;
         $display("FAIL same_cycle_bvalid: got %b, required 10000",
                  {bus.bvalid, bus.bresp, bus.awready, bus.wready});
      end
      step();
      tests_run++;
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
         tests_failed++;
         $display("FAIL same_cycle_bdone: got %b, required 011", {bus.bvalid, bus.awready, bus.wready});
      end
      exp_regs[1] = 32'hDEADBEEF;
      axi_read(32'h04, d, r);
      tests_run++;
      if ({d, r} !== {32'hDEADBEEF, 2'b00}) begin
         tests_failed++;
         $display("FAIL read_0x04: got %h/%b, required deadbeef/00", d, r);
      end
   endtask

   task automatic test_strobe();
      logic [31:0] d; logic [1:0] r;
      bus.wdata = 32'h000000AA; bus.wstrb = 4'h1; bus.wvalid = 1'b1; bus.bready = 1'b1;
      step();
      bus.wvalid = 1'b0;
      tests_run++;
      if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin
         tests_failed++;
         $display("FAIL w_first_latch: got %b, required 010", {bus.wready, bus.awready, bus.bvalid});
      end
      step();
      bus.awaddr = 32'h08; bus.awvalid = 1'b1;
      step();
      bus.awvalid = 1'b0;
      tests_run++;
      if ({bus.bvalid, bus.bresp} !== 3'b100) begin
         tests_failed++;
         $display("FAIL w_first_bvalid: got %b, required 100", {bus.bvalid, bus.bresp});
      end
      step();
      axi_write(32'h08, 32'h0000BB00, 4'h2, r);
      tests_run++;
      if (r !== 2'b00) begin
         tests_failed++;
         $display("FAIL strobe_bresp: got %b, required 00", r);
      end
      exp_regs[2] = 32'h0000BBAA;
      axi_read(32'h08, d, r);
      tests_run++;
      if ({d, r} !== {32'h0000BBAA, 2'b00}) begin
         tests_failed++;
         $display("FAIL strobe_merge: got %h/%b, required 0000bbaa/00", d, r);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] d; logic [1:0] r;
      axi_write(32'h40, 32'h12345678, 4'hF, r);
      tests_run++;
      if (r !== 2'b10) begin
         tests_failed++;
         $display("FAIL oor_bresp: got %b, required 10", r);
      end
      axi_read(32'h40, d, r);
      tests_run++;
      if ({d, r} !== {32'h0, 2'b10}) begin
         tests_failed++;
         $display("FAIL oor_read: got %h/%b, required 00000000/10", d, r);
      end
      for (int i = 0; i < 16; i++) begin
         axi_read(32'(i * 4), d, r);
         tests_run++;
         if ({d, r} !== {exp_regs[i], 2'b00}) begin
            tests_failed++;
            $display("FAIL oor_scan[%0d]: got %h/%b, required %h/00", i, d, r, exp_regs[i]);
         end
      end
   endtask

   task automatic test_bready_stall();
      logic [31:0] d; logic [1:0] r;
      bus.bready = 1'b0;
      bus.awaddr = 32'h10; bus.awvalid = 1'b1;
      bus.wdata = 32'h00000055; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      step();
      bus.wvalid = 1'b0;
      bus.awaddr = 32'h14;
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d]: got %b, required 10000", i,
                     {bus.bvalid, bus.bresp, bus.awready, bus.wready});
         end
         step();
      end
      bus.bready = 1'b1;
      step();
      bus.awvalid = 1'b0;
      tests_run++;
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
         tests_failed++;
         $display("FAIL stall_release: got %b, required 011", {bus.bvalid, bus.awready, bus.wready});
      end
      step();
      tests_run++;
      if ({bus.bvalid, bus.awready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL stall_no_second_aw: got %b, required 01", {bus.bvalid, bus.awready});
      end
      exp_regs[4] = 32'h00000055;
      axi_read(32'h10, d, r);
      tests_run++;
      if ({d, r} !== {32'h00000055, 2'b00}) begin
         tests_failed++;
         $display("FAIL stall_read_0x10: got %h/%b, required 00000055/00", d, r);
      end
      axi_read(32'h14, d, r);
      tests_run++;
      if ({d, r} !== {32'h0, 2'b00}) begin
         tests_failed++;
         $display("FAIL stall_read_0x14: got %h/%b, required 00000000/00", d, r);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d; logic [1:0] r;
      axi_write(32'h0C, 32'h11111111, 4'hF, r);
      bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
      bus.wdata = 32'h22222222; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      bus.araddr = 32'h0C; bus.arvalid = 1'b1;
      bus.bready = 1'b1; bus.rready = 1'b1;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      tests_run++;
      if ({bus.rvalid, bus.rdata, bus.bvalid} !== {1'b1, 32'h11111111, 1'b1}) begin
         tests_failed++;
         $display("FAIL simul_old_value: rvalid/rdata/bvalid got %b/%h/%b, required 1/11111111/1",
                  bus.rvalid, bus.rdata, bus.bvalid);
      end
      step();
      exp_regs[3] = 32'h22222222;
      axi_read(32'h0C, d, r);
      tests_run++;
      if ({d, r} !== {32'h22222222, 2'b00}) begin
         tests_failed++;
         $display("FAIL simul_new_value: got %h/%b, required 22222222/00", d, r);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic [1:0] r;
      bus.rready = 1'b0;
      bus.araddr = 32'h04; bus.arvalid = 1'b1;
      bus.awaddr = 32'h00; bus.awvalid = 1'b1; bus.wvalid = 1'b0;
      step();
      bus.arvalid = 1'b0; bus.awvalid = 1'b0;
      tests_run++;
      if ({bus.rvalid, bus.awready, bus.wready} !== 3'b101) begin
         tests_failed++;
         $display("FAIL mid_setup: got %b, required 101", {bus.rvalid, bus.awready, bus.wready});
      end
      #2;
      areset_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_outputs: got %b, required 00000",
                  {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
      end
      bus.rready = 1'b1;
      step();
      areset_n = 1'b1;
      step();
      for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
      for (int i = 0; i < 16; i++) begin
         axi_read(32'(i * 4), d, r);
         tests_run++;
         if ({d, r} !== {exp_regs[i], 2'b00}) begin
            tests_failed++;
            $display("FAIL mid_cleared[%0d]: got %h/%b, required 00000000/00", i, d, r);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      test_reset();
      test_same_cycle_write();
      test_strobe();
      test_out_of_range();
      test_bready_stall();
      test_simultaneous();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
`default_nettype wire
